fft8_seq: RTL and testbench
===========================

FFT8_SEQ -- requirements
Module: fft8_seq

Interface
REQ-001 SHALL provide parameter DATA_W, default 12, signed input sample width.
REQ-002 SHALL provide parameter TW_W, default 8, twiddle fraction bits; twiddle magnitude 0.70710678 is stored as round(0.70710678*2^TW_W), which is 181 at the default.
REQ-003 SHALL define OUT_W = DATA_W+3 as the internal and output word width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  in_data carries a sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_data  input  DATA_W  signed real time-domain sample.
REQ-009 out_valid  output  1  output bin is present.
REQ-010 out_ready  input  1  consumer accepts the bin.
REQ-011 out_re / out_im  output  OUT_W each  signed real and imaginary parts of the bin.
REQ-012 out_idx  output  3  bin index, 0..7.
REQ-013 out_last  output  1  high with bin 7.
REQ-014 mag_sq  output  2*OUT_W+1  unsigned value out_re^2 + out_im^2.
REQ-015 busy  output  1  high in COMPUTE and UNLOAD.

Function
REQ-016 SHALL compute the forward 8-point DFT X[k] = sum x[n]*e^(-j*2*pi*n*k/8), radix-2 DIT, using one butterfly per clock.
REQ-017 FSM states SHALL be LOAD, COMPUTE, UNLOAD; the reset state is LOAD.
REQ-018 LOAD: in_ready=1 and busy=0; each in_valid&&in_ready handshake writes the sample, sign-extended to OUT_W, at the bit-reversed address of the sample counter (0..7).
REQ-019 LOAD: the edge accepting the 8th sample SHALL clear the counter and enter COMPUTE.
REQ-020 COMPUTE: in_ready=0 for exactly 12 cycles, covering stages 0,1,2 with 4 butterflies each; the state then goes to UNLOAD, so out_valid is high 12 edges after the 8th-sample edge.
REQ-021 Twiddle W^0 SHALL bypass the multiplier.
REQ-022 Twiddle W^2 = -j SHALL be an exact swap/negate with no multiplier.
REQ-023 Twiddles W^1 and W^3 SHALL use products rounded as (p + 2^(TW_W-1)) >>> TW_W.
REQ-024 Butterflies SHALL never overflow OUT_W for any DATA_W input; no saturation logic is present.
REQ-025 UNLOAD: out_valid=1 and bins are presented in natural order 0..7; out_idx, out_re, out_im and mag_sq advance only on out_valid&&out_ready.
REQ-026 While out_valid && !out_ready, all out_* and mag_sq SHALL hold stable.
REQ-027 The handshake of bin 7 (out_last=1) SHALL return the FSM to LOAD, with in_ready=1 on the next cycle.
REQ-028 in_valid SHALL be ignored outside LOAD; no sample is stored or dropped-and-counted.
REQ-029 out_ready SHALL be ignored outside UNLOAD; out_valid=0 there.
REQ-030 All outputs SHALL be driven from registers or from state decode only; there is no combinational path from in_valid or out_ready to any output.

Reset
REQ-031 On a clk edge with rst_n=0: state=LOAD; counters=0; in_ready=1 after the edge; out_valid=0, out_last=0, busy=0; out_re=out_im=0, out_idx=0, mag_sq=0.
REQ-032 Reset in any state SHALL discard the partial frame; the next accepted sample is sample 0 of a new frame.
REQ-033 Sample memory contents need no reset value but SHALL never reach the outputs before being rewritten.

Configuration
REQ-034 Macro FFT8_SEQ_MAG_EN: when defined, mag_sq SHALL be registered alongside out_re/out_im, computed from the same bin.
REQ-035 When FFT8_SEQ_MAG_EN is undefined, the squaring logic SHALL be absent and mag_sq SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-036 Impulse: 100,0,0,0,0,0,0,0 -> every bin 100+0j, mag_sq=10000 (MAG_EN).
REQ-037 DC: eight samples of 50 -> bin0 = 400+0j; bins 1..7 = 0+0j.
REQ-038 Alternating 100,-100,... -> bin4 = 800+0j; all other bins 0.
REQ-039 Input 10,5,-10,12,-15,14,0,-9 -> bin0 = 7+0j, bin2 = 5-16j, bin4 = -37+0j exactly; bins 1,3,5,7 within +/-1 LSB of the double-precision DFT.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles at out_idx=3 -> outputs unchanged across those cycles; then one bin per cycle, out_last with idx 7, in_ready=1 on the next cycle.
REQ-041 Reset pulse during COMPUTE, then a DC frame of 50 -> bin0 = 400; no residue of the aborted frame appears.

Source files
------------

// File: rtl/fft8_seq.sv
// fft8_seq: sequential 8-point radix-2 DIT FFT, one in-place butterfly per clock.
// Define FFT8_SEQ_MAG_EN to register mag_sq = re^2 + im^2 alongside each output bin.
module fft8_seq #(
  parameter int DATA_W = 12,
  parameter int TW_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W+2:0]   out_re,
  output logic [DATA_W+2:0]   out_im,
  output logic [2:0]          out_idx,
  output logic                out_last,
  output logic [2*DATA_W+6:0] mag_sq,
  output logic                busy
);
  localparam int OUT_W  = DATA_W + 3;
  localparam int MAG_W  = 2 * OUT_W + 1;
  localparam int PROD_W = OUT_W + TW_W + 3;
  localparam int TW_C   = $rtoi(0.70710678 * (2.0 ** TW_W) + 0.5);
  localparam logic signed [PROD_W-1:0] TW_K = PROD_W'(TW_C);
  localparam logic signed [PROD_W-1:0] RND  = PROD_W'(1 << (TW_W - 1));

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t state, state_next;
  logic [2:0] cnt;
  logic [3:0] bfly;
  logic signed [OUT_W-1:0] mem_re [8];
  logic signed [OUT_W-1:0] mem_im [8];
  logic [2:0] top, bot, idx_nxt, load_idx;
  logic [1:0] tw;
  logic last_bfly, load_en;
  logic signed [OUT_W-1:0] a_re, a_im, b_re, b_im, t_re, t_im, r_sum, r_dif;
  logic signed [PROD_W-1:0] p_sum, p_dif;

  assign last_bfly = (bfly == 4'd11);
  assign idx_nxt   = out_idx + 3'd1;
  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == UNLOAD);
  assign out_last  = (state == UNLOAD) && (out_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_valid && cnt == 3'd7) state_next = COMPUTE;
      COMPUTE: if (last_bfly) state_next = UNLOAD;
      UNLOAD:  if (out_ready && out_idx == 3'd7) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // bfly[3:2] is the stage, bfly[1:0] the butterfly within it; tw is the W8 exponent
  always_comb begin
    top = 3'd0;
    bot = 3'd1;
    tw  = 2'd0;
    case (bfly[3:2])
      2'd0: begin
        top = {bfly[1:0], 1'b0};
        bot = {bfly[1:0], 1'b1};
      end
      2'd1: begin
        top = {bfly[1], 1'b0, bfly[0]};
        bot = {bfly[1], 1'b1, bfly[0]};
        tw  = {bfly[0], 1'b0};
      end
      2'd2: begin
        top = {1'b0, bfly[1:0]};
        bot = {1'b1, bfly[1:0]};
        tw  = bfly[1:0];
      end
      default: ;
    endcase
  end

  assign a_re = mem_re[top];
  assign a_im = mem_im[top];
  assign b_re = mem_re[bot];
  assign b_im = mem_im[bot];

  // W^1 = c(1-j), W^3 = c(-1-j): both reduce to scaled (re+im) and (im-re)
  always_comb begin
    p_sum = (PROD_W'(b_re) + PROD_W'(b_im)) * TW_K;
    p_dif = (PROD_W'(b_im) - PROD_W'(b_re)) * TW_K;
    r_sum = OUT_W'((p_sum + RND) >>> TW_W);
    r_dif = OUT_W'((p_dif + RND) >>> TW_W);
    t_re  = b_re;
    t_im  = b_im;
    case (tw)
      2'd1: begin t_re = r_sum; t_im = r_dif;  end
      2'd2: begin t_re = b_im;  t_im = -b_re;  end
      2'd3: begin t_re = r_dif; t_im = -r_sum; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == LOAD && in_valid) begin
      mem_re[{cnt[0], cnt[1], cnt[2]}] <= OUT_W'($signed(in_data));
      mem_im[{cnt[0], cnt[1], cnt[2]}] <= '0;
    end else if (rst_n && state == COMPUTE) begin
      mem_re[top] <= a_re + t_re;
      mem_im[top] <= a_im + t_im;
      mem_re[bot] <= a_re - t_re;
      mem_im[bot] <= a_im - t_im;
    end
  end

  // Output registers load bin 0 on the last butterfly, then the next bin per handshake
  always_comb begin
    load_en  = 1'b0;
    load_idx = 3'd0;
    if (state == COMPUTE && last_bfly) begin
      load_en = 1'b1;
    end else if (state == UNLOAD && out_ready && out_idx != 3'd7) begin
      load_en  = 1'b1;
      load_idx = idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 3'd0;
      bfly    <= 4'd0;
      out_re  <= '0;
      out_im  <= '0;
      out_idx <= 3'd0;
    end else begin
      if (state == LOAD && in_valid) cnt <= cnt + 3'd1;
      if (state == COMPUTE) bfly <= last_bfly ? 4'd0 : bfly + 4'd1;
      if (load_en) begin
        out_re  <= mem_re[load_idx];
        out_im  <= mem_im[load_idx];
        out_idx <= load_idx;
      end
    end
  end

`ifdef FFT8_SEQ_MAG_EN
  logic signed [MAG_W-1:0] sq_re, sq_im;
  assign sq_re = MAG_W'(mem_re[load_idx]);
  assign sq_im = MAG_W'(mem_im[load_idx]);

  always_ff @(posedge clk) begin
    if (!rst_n)       mag_sq <= '0;
    else if (load_en) mag_sq <= sq_re * sq_re + sq_im * sq_im;
  end
`else
  assign mag_sq = '0;
`endif

endmodule

// File: tb/tb_fft8_seq.sv
// tb_fft8_seq: directed frames for fft8_seq checked against a floating-point DFT model.
module tb_fft8_seq;
  localparam int DW = 12;
  localparam int OW = DW + 3;
  localparam int MW = 2 * OW + 1;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    real re;
    real im;
    int  idx;
  } bin_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_re;
  logic [OW-1:0] out_im;
  logic [2:0]    out_idx;
  logic          out_last;
  logic [MW-1:0] mag_sq;
  logic          busy;

  int   nTotal = 0;
  int   nBad   = 0;
  bin_t expQ[$];
  int   gotRe[8];
  int   gotIm[8];
  int   frm[8];

  fft8_seq #(.DATA_W(DW), .TW_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .mag_sq(mag_sq), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hung, required finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic bit isExact(input real v);
    return rabs(v - $floor(v + 0.5)) < 1.0e-6;
  endfunction

  function automatic int rnd(input real v);
    return $rtoi($floor(v + 0.5));
  endfunction

  task automatic checkOutput(input string name, input longint got, input longint exp);
    nTotal++;
    if (got != exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Integer-valued reference bins must match exactly, others within one LSB
  task automatic checkNear(input string name, input int got, input real exp);
    bit bad;
    nTotal++;
    if (isExact(exp)) bad = (got != rnd(exp));
    else              bad = rabs(real'(got) - exp) > 1.0;
    if (bad) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, required %f", name, got, exp);
    end
  endtask

  task automatic pushModel(input int x[8]);
    bin_t b;
    real  ang;
    for (int k = 0; k < 8; k++) begin
      b.re  = 0.0;
      b.im  = 0.0;
      b.idx = k;
      for (int n = 0; n < 8; n++) begin
        ang  = 2.0 * PI * real'(n * k) / 8.0;
        b.re = b.re + real'(x[n]) * $cos(ang);
        b.im = b.im - real'(x[n]) * $sin(ang);
      end
      expQ.push_back(b);
    end
  endtask

  // Every cycle a bin is presented it must equal the model's head bin; it pops on handshake
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        nTotal++;
        nBad++;
        $display("[TB] FAIL unexpectedBin: got idx %0d, required no output", out_idx);
      end else begin
        checkOutput("binIdx", out_idx, expQ[0].idx);
        checkOutput("binLast", out_last, (expQ[0].idx == 7) ? 1 : 0);
        checkNear("binRe", $signed(out_re), expQ[0].re);
        checkNear("binIm", $signed(out_im), expQ[0].im);
`ifdef FFT8_SEQ_MAG_EN
        if (isExact(expQ[0].re) && isExact(expQ[0].im))
          checkOutput("magSq", mag_sq,
                      longint'(rnd(expQ[0].re)) * rnd(expQ[0].re) +
                      longint'(rnd(expQ[0].im)) * rnd(expQ[0].im));
`else
        checkOutput("magTied", mag_sq, 0);
`endif
        if (out_ready) begin
          gotRe[out_idx] = $signed(out_re);
          gotIm[out_idx] = $signed(out_im);
          void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int x[8], input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) checkOutput("loadInReady", in_ready, 1);
      in_valid = 1'b1;
      in_data  = DW'(x[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitCompute(input bit garbage);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      checkOutput("computeInReady", in_ready, 0);
      checkOutput("computeBusy", busy, 1);
      if (garbage) begin
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("latency", lat, 12);
  endtask

  task automatic runUnload(input int stallIdx, input int stallLen);
    int cyc = 0;
    int stalled = 0;
    bit done = 0;
    bit hs;
    for (int i = 0; i < 8; i++) begin
      gotRe[i] = 99999;
      gotIm[i] = 99999;
    end
    while (!done && cyc < 100) begin
      if (out_valid && out_idx == 3'(stallIdx) && stalled < stallLen) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      hs = out_valid && out_ready && out_last;
      @(posedge clk); #1;
      cyc++;
      if (hs) done = 1;
    end
    out_ready = 1'b0;
    if (!done) begin
      nTotal++;
      nBad++;
      $display("[TB] FAIL unloadTimeout: got no last handshake, required one within 100 cycles");
    end
    checkOutput("unloadCycles", cyc, 8 + stallLen);
    checkOutput("afterInReady", in_ready, 1);
    checkOutput("afterOutValid", out_valid, 0);
    checkOutput("afterBusy", busy, 0);
  endtask

  task automatic runFrame(input int x[8], input int stallIdx, input int stallLen, input bit garbage);
    pushModel(x);
    applyStimulus(x, 8);
    waitCompute(garbage);
    runUnload(stallIdx, stallLen);
    checkOutput("queueDrained", expQ.size(), 0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rstInReady", in_ready, 1);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstOutLast", out_last, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOutRe", out_re, 0);
    checkOutput("rstOutIm", out_im, 0);
    checkOutput("rstOutIdx", out_idx, 0);
    checkOutput("rstMagSq", mag_sq, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    pulseReset();

    frm = '{100, 0, 0, 0, 0, 0, 0, 0};
    runFrame(frm, -1, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("impulseRe", gotRe[k], 100);
      checkOutput("impulseIm", gotIm[k], 0);
    end

    frm = '{50, 50, 50, 50, 50, 50, 50, 50};
    runFrame(frm, -1, 0, 1'b0);
    checkOutput("dcBin0Re", gotRe[0], 400);
    checkOutput("dcBin0Im", gotIm[0], 0);
    checkOutput("dcBin5Re", gotRe[5], 0);

    frm = '{100, -100, 100, -100, 100, -100, 100, -100};
    runFrame(frm, -1, 0, 1'b0);
    checkOutput("altBin4Re", gotRe[4], 800);
    checkOutput("altBin1Re", gotRe[1], 0);

    frm = '{10, 5, -10, 12, -15, 14, 0, -9};
    runFrame(frm, 3, 5, 1'b1);
    checkOutput("mixBin0Re", gotRe[0], 7);
    checkOutput("mixBin0Im", gotIm[0], 0);
    checkOutput("mixBin2Re", gotRe[2], 5);
    checkOutput("mixBin2Im", gotIm[2], -16);
    checkOutput("mixBin4Re", gotRe[4], -37);
    checkOutput("mixBin4Im", gotIm[4], 0);

    frm = '{-2000, 1999, -1500, 700, 2047, -2048, 33, -1};
    applyStimulus(frm, 8);
    repeat (4) begin
      @(posedge clk); #1;
    end
    pulseReset();
    frm = '{50, 50, 50, 50, 50, 50, 50, 50};
    runFrame(frm, 3, 5, 1'b0);
    checkOutput("abortDcBin0", gotRe[0], 400);
    checkOutput("abortDcBin4", gotRe[4], 0);

    frm = '{700, 800, 900, 0, 0, 0, 0, 0};
    applyStimulus(frm, 3);
    pulseReset();
    frm = '{100, -100, 100, -100, 100, -100, 100, -100};
    runFrame(frm, 6, 2, 1'b0);
    checkOutput("partialAltBin4", gotRe[4], 800);
    checkOutput("partialAltBin0", gotRe[0], 0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end
endmodule
